// File: rtl/switch_press_classifier.sv
// switch_press_classifier: synchronise, debounce and classify a push-button as click or long press
module switch_press_classifier #(
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int LONG_PRESS_LIMIT = 25000000,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_Switch,
  output logic o_Switch,
  output logic o_Press,
  output logic o_Release,
  output logic o_Click,
  output logic o_Long_Press
);
  localparam int DW = $clog2(DEBOUNCE_LIMIT);
  localparam int HW = $clog2(LONG_PRESS_LIMIT);
  typedef enum logic [1:0] {IDLE, PRESSED, LONG_HELD} state_t;
  state_t state, state_n;
  logic s1, s2;
  logic [DW-1:0] cnt;
  logic [HW-1:0] hold, hold_n;
  logic accept, rise, fall, hold_end;
  logic press_n, release_n, click_n, long_n;
  // accept fires on the edge that flips o_Switch, letting the FSM register its pulses on that same edge
  assign accept = (s2 != o_Switch) && (cnt == DW'(DEBOUNCE_LIMIT - 1));
  assign rise = accept & s2;
  assign fall = accept & ~s2;
  assign hold_end = hold == HW'(LONG_PRESS_LIMIT - 1);
  // two-flop synchroniser on the normalised input, then the debounce counter
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      cnt <= '0;
      o_Switch <= 1'b0;
    end else begin
      s1 <= i_Switch ^ ACTIVE_LOW;
      s2 <= s1;
      cnt <= (s2 == o_Switch || accept) ? '0 : cnt + DW'(1);
      if (accept) o_Switch <= s2;
    end
  end
  // FSM state, hold counter and registered event pulses
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state <= IDLE;
      hold <= '0;
      o_Press <= 1'b0;
      o_Release <= 1'b0;
      o_Click <= 1'b0;
      o_Long_Press <= 1'b0;
    end else begin
      state <= state_n;
      hold <= hold_n;
      o_Press <= press_n;
      o_Release <= release_n;
      o_Click <= click_n;
      o_Long_Press <= long_n;
    end
  end
  // next state and pulses; a release on the long-press edge wins and counts as a click
  always_comb begin
    state_n = state;
    hold_n = hold;
    press_n = 1'b0;
    release_n = 1'b0;
    click_n = 1'b0;
    long_n = 1'b0;
    case (state)
      IDLE: if (rise) begin
        state_n = PRESSED;
        hold_n = '0;
        press_n = 1'b1;
      end
      PRESSED: begin
        hold_n = hold_end ? hold : hold + HW'(1);
        if (fall) begin
          state_n = IDLE;
          release_n = 1'b1;
          click_n = 1'b1;
        end else if (hold_end) begin
          state_n = LONG_HELD;
          long_n = 1'b1;
        end
      end
      LONG_HELD: if (fall) begin
        state_n = IDLE;
        release_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_switch_press_classifier.sv
// tb_switch_press_classifier: directed checks of debounce latency, click/long classification and reset
module tb_switch_press_classifier;
  logic clk = 1'b0, rst = 1'b1, a_sw = 1'b0, b_sw = 1'b1;
  logic a_s, a_p, a_r, a_c, a_l, b_s, b_p, b_r, b_c, b_l;
  logic [4:0] a_out, b_out;
  int vectors = 0, errors = 0;
  assign a_out = {a_s, a_p, a_r, a_c, a_l};
  assign b_out = {b_s, b_p, b_r, b_c, b_l};
  always #5 clk = ~clk;
  switch_press_classifier #(.DEBOUNCE_LIMIT(4), .LONG_PRESS_LIMIT(10), .ACTIVE_LOW(1'b0)) dut_a (
    .i_Clk(clk), .i_Reset(rst), .i_Switch(a_sw), .o_Switch(a_s), .o_Press(a_p),
    .o_Release(a_r), .o_Click(a_c), .o_Long_Press(a_l));
  switch_press_classifier #(.DEBOUNCE_LIMIT(4), .LONG_PRESS_LIMIT(10), .ACTIVE_LOW(1'b1)) dut_b (
    .i_Clk(clk), .i_Reset(rst), .i_Switch(b_sw), .o_Switch(b_s), .o_Press(b_p),
    .o_Release(b_r), .o_Click(b_c), .o_Long_Press(b_l));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [4:0] e(input bit s, input bit p, input bit r, input bit c, input bit l);
    return {s, p, r, c, l};
  endfunction
  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask
  initial begin
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk($sformatf("reset k%0d", k), a_out, 5'b0);
      chk($sformatf("reset_b k%0d", k), b_out, 5'b0);
    end
    rst = 1'b0;
    chk("post_reset", a_out, 5'b0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk($sformatf("idle k%0d", k), a_out, 5'b0);
    end
    a_sw = 1'b1;
    b_sw = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      chk($sformatf("hold k%0d", k), a_out, e(k >= 6, k == 6, 0, 0, k == 16));
      chk($sformatf("hold_b k%0d", k), b_out, e(k >= 6, k == 6, 0, 0, k == 16));
    end
    a_sw = 1'b0;
    b_sw = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("long_rel k%0d", k), a_out, e(k < 6, 0, k == 6, 0, 0));
      chk($sformatf("long_rel_b k%0d", k), b_out, e(k < 6, 0, k == 6, 0, 0));
    end
    a_sw = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("short k%0d", k), a_out, e(k >= 6, k == 6, 0, 0, 0));
    end
    a_sw = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("short_rel k%0d", k), a_out, e(k < 6, 0, k == 6, k == 6, 0));
    end
    a_sw = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk($sformatf("blip k%0d", k), a_out, 5'b0);
    end
    a_sw = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk($sformatf("blip_after k%0d", k), a_out, 5'b0);
    end
    for (int k = 0; k < 5; k++) begin
      a_sw = k inside {0, 2, 3};
      tick();
      chk($sformatf("bounce k%0d", k), a_out, 5'b0);
    end
    a_sw = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk($sformatf("bounce_hold k%0d", k), a_out, e(k >= 6, k == 6, 0, 0, k == 16));
    end
    a_sw = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("bounce_rel k%0d", k), a_out, e(k < 6, 0, k == 6, 0, 0));
    end
    a_sw = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk($sformatf("tie k%0d", k), a_out, e(k >= 6, k == 6, 0, 0, 0));
    end
    a_sw = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("tie_rel k%0d", k), a_out, e(k < 6, 0, k == 6, k == 6, 0));
    end
    a_sw = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("pre_rst k%0d", k), a_out, e(k >= 6, k == 6, 0, 0, 0));
    end
    rst = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      tick();
      chk($sformatf("mid_rst k%0d", k), a_out, 5'b0);
    end
    rst = 1'b0;
    chk("mid_rst_fall", a_out, 5'b0);
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk($sformatf("after_rst k%0d", k), a_out, e(k >= 6, k == 6, 0, 0, k == 16));
    end
    a_sw = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("after_rst_rel k%0d", k), a_out, e(k < 6, 0, k == 6, 0, 0));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
